// File: rtl/conv_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// conv_frame_ctrl_if
// Purpose : bundles every non-clock/reset signal of the convolution frame
//           controller. Names are from the controller's point of view
//           (i_ = into the controller, o_ = out of the controller).
// Signals :
//   i_start, i_abort          frame control pulses
//   i_pix_valid, i_pix        raw pixel stream (no backpressure)
//   o_conv_valid, o_conv_val  pixel forwarded to the 3x3 core
//   i_conv_res                registered result from the 3x3 core
//   o_res_valid, o_res,
//   o_res_x, o_res_y          tagged result stream
//   o_busy, o_frame_done,
//   o_overrun                 status
// Modports:
//   slave  - the controller itself
//   master - frame source / core stand-in driving the controller
// ----------------------------------------------------------------------------
interface conv_frame_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int RW = DATA_WIDTH + 3;

    logic                  i_start;
    logic                  i_abort;
    logic                  i_pix_valid;
    logic [DATA_WIDTH-1:0] i_pix;
    logic                  o_conv_valid;
    logic [DATA_WIDTH-1:0] o_conv_val;
    logic [RW-1:0]         i_conv_res;
    logic                  o_res_valid;
    logic [RW-1:0]         o_res;
    logic [XW-1:0]         o_res_x;
    logic [YW-1:0]         o_res_y;
    logic                  o_busy;
    logic                  o_frame_done;
    logic                  o_overrun;

    modport slave (
        input  i_start, i_abort, i_pix_valid, i_pix, i_conv_res,
        output o_conv_valid, o_conv_val, o_res_valid, o_res, o_res_x, o_res_y,
               o_busy, o_frame_done, o_overrun
    );

    modport master (
        output i_start, i_abort, i_pix_valid, i_pix, i_conv_res,
        input  o_conv_valid, o_conv_val, o_res_valid, o_res, o_res_x, o_res_y,
               o_busy, o_frame_done, o_overrun
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// ----------------------------------------------------------------------------
// conv_frame_ctrl
// Purpose : frame-level sequencer in front of the 3x3 streaming convolution
//           core. Forwards pixels to the core only inside an armed frame,
//           tracks the (x, y) position of every accepted pixel, drops results
//           whose 3x3 window is incomplete (top/left border), tags the kept
//           results with the window's bottom-right coordinate and pulses
//           o_frame_done once the pipeline has drained.
// Ports   :
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      conv_frame_ctrl_if.slave (control, pixel in, core link,
//            result out, status)
// Timing  : pixel accepted in cycle t -> o_conv_valid in t+1 -> core output
//           register in t+2 -> o_res_valid in t+3.
// Config  : define CONV_CTRL_BORDER_ZERO_EN to emit a result for every pixel,
//           with border windows forced to 0. Undefined (default): only full
//           windows are emitted.
// Params  : N must be 3; IMG_WIDTH must equal the core line-buffer depth;
//           IMG_WIDTH and IMG_HEIGHT must be at least 3.
// ----------------------------------------------------------------------------
module conv_frame_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int N          = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    conv_frame_ctrl_if.slave bus
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int RW = DATA_WIDTH + 3;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    // First column/row whose window reaches N-1 pixels back: a full window.
    localparam logic [XW-1:0] X_FULL = XW'(N - 1);
    localparam logic [YW-1:0] Y_FULL = YW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    // Tag pipe: p0 travels with the core input, p1 with the core output,
    // the third stage is the o_res* register set itself.
    logic          r_vld_p0;
    logic          r_vld_p1;
    logic [XW-1:0] r_x_p0;
    logic [XW-1:0] r_x_p1;
    logic [YW-1:0] r_y_p0;
    logic [YW-1:0] r_y_p1;
    logic          r_keep_p0;
    logic          r_keep_p1;

    logic          w_accept;
    logic          w_keep;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_emit;
    logic          w_emit_ok;
    logic [RW-1:0] w_res;

    // A pixel in the same cycle as an abort is dropped with the frame.
    assign w_accept = (r_state == ST_RUN) && bus.i_pix_valid && !bus.i_abort;
    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);
    assign w_keep   = (r_x >= X_FULL) && (r_y >= Y_FULL);

`ifdef CONV_CTRL_BORDER_ZERO_EN
    assign w_emit = r_vld_p1;
    assign w_res  = r_keep_p1 ? bus.i_conv_res : '0;
`else
    assign w_emit = r_vld_p1 && r_keep_p1;
    assign w_res  = bus.i_conv_res;
`endif

    // Abort flushes the last stage as well, so nothing in flight surfaces.
    assign w_emit_ok = w_emit && !bus.i_abort;

    // ---- control, counters, tag valids and registered outputs ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_x              <= '0;
            r_y              <= '0;
            r_vld_p0         <= 1'b0;
            r_vld_p1         <= 1'b0;
            bus.o_conv_valid <= 1'b0;
            bus.o_conv_val   <= '0;
            bus.o_res_valid  <= 1'b0;
            bus.o_res        <= '0;
            bus.o_res_x      <= '0;
            bus.o_res_y      <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_frame_done <= 1'b0;
            bus.o_overrun    <= 1'b0;
        end else begin
            bus.o_conv_valid <= w_accept;
            bus.o_frame_done <= 1'b0;
            r_vld_p0         <= w_accept;
            r_vld_p1         <= r_vld_p0;
            bus.o_res_valid  <= w_emit_ok;

            if (w_accept) begin
                bus.o_conv_val <= bus.i_pix;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end

            // Suppressed tags leave the result registers untouched.
            if (w_emit_ok) begin
                bus.o_res   <= w_res;
                bus.o_res_x <= r_x_p1;
                bus.o_res_y <= r_y_p1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_state       <= ST_RUN;
                        r_x           <= '0;
                        r_y           <= '0;
                        bus.o_overrun <= 1'b0;
                        bus.o_busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept && w_x_last && w_y_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // With p0/p1 empty, the final tag sits in the output stage
                    // this cycle, so the done pulse lands one cycle after it.
                    if (!r_vld_p0 && !r_vld_p1) begin
                        r_state          <= ST_IDLE;
                        bus.o_busy       <= 1'b0;
                        bus.o_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase

            // A pixel arriving outside RUN is lost; this wins over the clear
            // from a start in the same cycle because that pixel really was lost.
            if (bus.i_pix_valid && (r_state != ST_RUN)) begin
                bus.o_overrun <= 1'b1;
            end

            if (bus.i_abort) begin
                r_state          <= ST_IDLE;
                r_vld_p0         <= 1'b0;
                r_vld_p1         <= 1'b0;
                bus.o_busy       <= 1'b0;
                bus.o_frame_done <= 1'b0;
            end
        end
    end

    // ---- tag payload pipe (valids above qualify it) ----
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_x_p0    <= r_x;
            r_y_p0    <= r_y;
            r_keep_p0 <= w_keep;
        end
        if (r_vld_p0) begin
            r_x_p1    <= r_x_p0;
            r_y_p1    <= r_y_p0;
            r_keep_p1 <= r_keep_p0;
        end
    end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl on an 8x4 image. A Sobel core stand-in
// (|gx|+|gy| over a stream delay line) supplies i_conv_res; expected results
// are computed from a 2-D frame array and the controller's frame rules.
module tb_conv_frame_ctrl;
    localparam int DW = 12;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int RW = DW + 3;
`ifdef CONV_CTRL_BORDER_ZERO_EN
    localparam int N_RES = W * H;
    localparam int FX = 0;
    localparam int FY = 0;
`else
    localparam int N_RES = (W - 2) * (H - 2);
    localparam int FX = 2;
    localparam int FY = 2;
`endif

    typedef int win_t [3][3];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_frame_ctrl_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    conv_frame_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .N(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic int mag3(input win_t w);
        int gx, gy;
        gx = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
        gy = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
        return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    endfunction

    // Core stand-in: line buffers of depth W as a flat delay line, output registered.
    int hist [2*W+3];
    function automatic int stream_mag(input int newest);
        win_t w;
        int   e;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                e = (2 - r) * W + (2 - c);
                w[r][c] = (e == 0) ? newest : hist[e-1];
            end
        return mag3(w);
    endfunction

    always @(posedge clk) begin
        if (bus.o_conv_valid) begin
            for (int i = 2*W+2; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= int'(bus.o_conv_val);
            bus.i_conv_res <= RW'(stream_mag(int'(bus.o_conv_val)));
        end
    end

    // Monitor
    int res_q[$], rx_q[$], ry_q[$], rc_q[$], done_q[$];
    int conv_cnt = 0;
    always @(negedge clk) begin
        if (bus.o_res_valid) begin
            res_q.push_back(int'(bus.o_res));
            rx_q.push_back(int'(bus.o_res_x));
            ry_q.push_back(int'(bus.o_res_y));
            rc_q.push_back(cyc);
        end
        if (bus.o_frame_done) done_q.push_back(cyc);
        if (bus.o_conv_valid) conv_cnt <= conv_cnt + 1;
    end

    // Reference model state
    int frame [H][W];
    int ex_v[$], ex_x[$], ex_y[$], ex_c[$];
    int last_acc;

    function automatic int ref_mag(input int x, input int y);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w[r][c] = frame[y-2+r][x-2+c];
        return mag3(w);
    endfunction

    // mode 0: constant 5, 1: x*10 every other cycle, 2: random (random gaps if gaps=1)
    task automatic drive_frame(input int mode, input bit gaps, input int npix, input bit start_mid);
        int v, x, y, gap;
        ex_v.delete(); ex_x.delete(); ex_y.delete(); ex_c.delete();
        res_q.delete(); rx_q.delete(); ry_q.delete(); rc_q.delete(); done_q.delete();
        @(negedge clk);
        bus.i_start = 1'b1;
        for (int k = 0; k < npix; k++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            x = k % W;
            y = k / W;
            case (mode)
                0:       v = 5;
                1:       v = x * 10;
                default: v = int'($urandom_range(0, (1 << DW) - 1));
            endcase
            gap = (mode == 1) ? 1 : (gaps ? int'($urandom_range(0, 2)) : 0);
            if (gap > 0) begin
                bus.i_pix_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            bus.i_pix_valid = 1'b1;
            bus.i_pix       = DW'(v);
            if (start_mid && k == W + 1) bus.i_start = 1'b1;
            frame[y][x] = v;
            last_acc    = cyc;
            if (x >= 2 && y >= 2) begin
                ex_v.push_back(ref_mag(x, y)); ex_x.push_back(x); ex_y.push_back(y); ex_c.push_back(cyc + 3);
            end
`ifdef CONV_CTRL_BORDER_ZERO_EN
            else begin
                ex_v.push_back(0); ex_x.push_back(x); ex_y.push_back(y); ex_c.push_back(cyc + 3);
            end
`endif
        end
    endtask

    task automatic end_pixels();
        @(negedge clk);
        bus.i_pix_valid = 1'b0;
        bus.i_start     = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_q.size() == 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.o_conv_valid, bus.o_res_valid, bus.o_busy, bus.o_frame_done, bus.o_overrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {bus.o_conv_valid, bus.o_res_valid, bus.o_busy, bus.o_frame_done, bus.o_overrun});
        end
        n_chk++;
        if (bus.o_res !== '0) begin n_fail++; $display("FAIL reset_res: got %0d required 0", bus.o_res); end
        n_chk++;
        if ({bus.o_res_x, bus.o_res_y} !== '0) begin
            n_fail++; $display("FAIL reset_xy: got (%0d,%0d) required (0,0)", bus.o_res_x, bus.o_res_y);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", bus.o_busy); end
    endtask

    task automatic test_const_frame();
        drive_frame(0, 1'b0, W * H, 1'b0);
        end_pixels();
        wait_done(40);
        n_chk++;
        if (res_q.size() !== N_RES) begin n_fail++; $display("FAIL const_count: got %0d required %0d", res_q.size(), N_RES); end
        if (res_q.size() > 0) begin
            n_chk++;
            if (rx_q[0] !== FX || ry_q[0] !== FY) begin
                n_fail++; $display("FAIL const_first_xy: got (%0d,%0d) required (%0d,%0d)", rx_q[0], ry_q[0], FX, FY);
            end
            n_chk++;
            if (rx_q[res_q.size()-1] !== W - 1 || ry_q[res_q.size()-1] !== H - 1) begin
                n_fail++; $display("FAIL const_last_xy: got (%0d,%0d) required (%0d,%0d)", rx_q[res_q.size()-1], ry_q[res_q.size()-1], W - 1, H - 1);
            end
        end
        foreach (res_q[i]) begin
            n_chk++;
            if (res_q[i] !== 0) begin n_fail++; $display("FAIL const_val[%0d]: got %0d required 0", i, res_q[i]); end
        end
        n_chk++;
        if (done_q.size() !== 1) begin
            n_fail++; $display("FAIL const_done_count: got %0d required 1", done_q.size());
        end else begin
            n_chk++;
            if (done_q[0] !== last_acc + 4) begin
                n_fail++; $display("FAIL const_done_cycle: got %0d required %0d", done_q[0], last_acc + 4);
            end
        end
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL const_busy_after: got %b required 0", bus.o_busy); end
    endtask

    task automatic test_ramp_gaps();
        int e;
        drive_frame(1, 1'b1, W * H, 1'b0);
        end_pixels();
        wait_done(40);
        n_chk++;
        if (res_q.size() !== N_RES) begin n_fail++; $display("FAIL ramp_count: got %0d required %0d", res_q.size(), N_RES); end
        for (int i = 0; i < res_q.size() && i < ex_x.size(); i++) begin
            e = (ex_x[i] >= 2 && ex_y[i] >= 2) ? 80 : 0;
            n_chk++;
            if (res_q[i] !== e) begin n_fail++; $display("FAIL ramp_val[%0d]: got %0d required %0d", i, res_q[i], e); end
            n_chk++;
            if (rx_q[i] !== ex_x[i] || ry_q[i] !== ex_y[i]) begin
                n_fail++; $display("FAIL ramp_xy[%0d]: got (%0d,%0d) required (%0d,%0d)", i, rx_q[i], ry_q[i], ex_x[i], ex_y[i]);
            end
            n_chk++;
            if (rc_q[i] !== ex_c[i]) begin n_fail++; $display("FAIL ramp_latency[%0d]: got cycle %0d required %0d", i, rc_q[i], ex_c[i]); end
        end
        n_chk++;
        if (done_q.size() !== 1) begin n_fail++; $display("FAIL ramp_done: got %0d pulses required 1", done_q.size()); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 2; f++) begin
            drive_frame(2, (f == 0), W * H, (f == 0));
            end_pixels();
            wait_done(60);
            n_chk++;
            if (res_q.size() !== ex_v.size()) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", f, res_q.size(), ex_v.size());
            end
            for (int i = 0; i < res_q.size() && i < ex_v.size(); i++) begin
                n_chk++;
                if (res_q[i] !== ex_v[i] || rx_q[i] !== ex_x[i] || ry_q[i] !== ex_y[i] || rc_q[i] !== ex_c[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_res[%0d]: got %0d@(%0d,%0d) cyc %0d required %0d@(%0d,%0d) cyc %0d",
                             f, i, res_q[i], rx_q[i], ry_q[i], rc_q[i], ex_v[i], ex_x[i], ex_y[i], ex_c[i]);
                end
            end
            n_chk++;
            if (done_q.size() !== 1) begin
                n_fail++; $display("FAIL rand%0d_done_count: got %0d required 1", f, done_q.size());
            end else begin
                n_chk++;
                if (done_q[0] !== last_acc + 4) begin
                    n_fail++; $display("FAIL rand%0d_done_cycle: got %0d required %0d", f, done_q[0], last_acc + 4);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int snap;
        @(negedge clk);
        n_chk++;
        if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_initial: got %b required 0", bus.o_overrun); end
        snap = conv_cnt;
        for (int k = 0; k < 3; k++) begin
            bus.i_pix_valid = 1'b1;
            bus.i_pix       = DW'($urandom_range(0, 4095));
            @(negedge clk);
        end
        bus.i_pix_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (conv_cnt !== snap) begin n_fail++; $display("FAIL ovr_forwarded: got %0d conv strobes required 0", conv_cnt - snap); end
        n_chk++;
        if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", bus.o_overrun); end
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        n_chk++;
        if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b required 0", bus.o_overrun); end
        n_chk++;
        if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b required 1", bus.o_busy); end
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
    endtask

    task automatic test_abort();
        int ab;
        drive_frame(2, 1'b0, 20, 1'b0);
        @(negedge clk);
        bus.i_pix_valid = 1'b0;
        bus.i_abort     = 1'b1;
        ab = cyc;
        @(negedge clk);
        bus.i_abort = 1'b0;
        repeat (12) @(negedge clk);
        foreach (rc_q[i]) begin
            n_chk++;
            if (rc_q[i] > ab) begin n_fail++; $display("FAIL abort_late_res: got result at cycle %0d required none after %0d", rc_q[i], ab); end
        end
        n_chk++;
        if (done_q.size() !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses required 0", done_q.size()); end
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", bus.o_busy); end
        drive_frame(2, 1'b1, W * H, 1'b0);
        end_pixels();
        wait_done(60);
        n_chk++;
        if (res_q.size() !== N_RES) begin n_fail++; $display("FAIL abort_refill_count: got %0d required %0d", res_q.size(), N_RES); end
        for (int i = 0; i < res_q.size() && i < ex_v.size(); i++) begin
            n_chk++;
            if (res_q[i] !== ex_v[i] || rx_q[i] !== ex_x[i] || ry_q[i] !== ex_y[i]) begin
                n_fail++;
                $display("FAIL abort_refill_res[%0d]: got %0d@(%0d,%0d) required %0d@(%0d,%0d)", i, res_q[i], rx_q[i], ry_q[i], ex_v[i], ex_x[i], ex_y[i]);
            end
        end
    endtask

    task automatic test_abort_start();
        drive_frame(2, 1'b0, 5, 1'b0);
        @(negedge clk);
        bus.i_pix_valid = 1'b0;
        bus.i_abort     = 1'b1;
        bus.i_start     = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abst_busy_next: got %b required 0", bus.o_busy); end
        repeat (8) @(negedge clk);
        n_chk++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abst_busy_later: got %b required 0", bus.o_busy); end
        n_chk++;
        if (done_q.size() !== 0) begin n_fail++; $display("FAIL abst_done: got %0d pulses required 0", done_q.size()); end
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_pix_valid = 1'b0;
        bus.i_pix       = '0;
        test_reset();
        test_const_frame();
        test_ramp_gaps();
        test_random_frames();
        test_overrun();
        test_abort();
        test_abort_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame-level sequencer in front of the 3x3 streaming convolution core (line buffers plus 3x3 window).
- Accepts a raw pixel stream and forwards pixels to the core only inside an armed frame.
- Tracks column/row position; drops results whose 3x3 window is incomplete (top/left border); tags kept results with coordinates.
- Signals frame completion after the pipeline has drained.

Parameters:
- DATA_WIDTH, 12, pixel width; result width is DATA_WIDTH+3.
- IMG_WIDTH, 640, pixels per row; must equal the core's line-buffer depth; minimum 3.
- IMG_HEIGHT, 480, rows per frame; minimum 3.
- N, 3, window size; only 3 is supported.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse: arm a new frame.
- i_abort  in  1  one-cycle pulse: abandon the current frame.
- i_pix_valid  in  1  input pixel strobe (no backpressure).
- i_pix  in  DATA_WIDTH  input pixel.
- o_conv_valid  out  1  to core i_val_valid.
- o_conv_val  out  DATA_WIDTH  to core i_val.
- i_conv_res  in  DATA_WIDTH+3  from core o_val.
- o_res_valid  out  1  result strobe.
- o_res  out  DATA_WIDTH+3  gradient magnitude.
- o_res_x  out  $clog2(IMG_WIDTH)  column of the window's bottom-right pixel.
- o_res_y  out  $clog2(IMG_HEIGHT)  row of the window's bottom-right pixel.
- o_busy  out  1  high in RUN or DRAIN.
- o_frame_done  out  1  one-cycle pulse at end of frame.
- o_overrun  out  1  sticky: pixel received while not in RUN.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; tag pipe cleared.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - i_start -> RUN; clears x, y and o_overrun.
  - i_pix_valid in IDLE or DRAIN: pixel dropped, not forwarded; sets o_overrun.
- RUN, per accepted pixel:
  - o_conv_valid/o_conv_val are registered copies of i_pix_valid/i_pix (1 cycle).
  - Tag {x, y, keep} enters a 3-stage tag pipe; keep = (x>=2 && y>=2).
  - x increments; at IMG_WIDTH-1, x wraps to 0 and y increments.
  - Pixel (IMG_WIDTH-1, IMG_HEIGHT-1) -> DRAIN.
- Latency: pixel accepted in cycle t -> core input valid t+1 -> core output register t+2 -> o_res* valid in cycle t+3.
  - o_res samples i_conv_res when tag stage 2 is valid; the tag pipe is authoritative.
  - i_conv_res is otherwise ignored.
- o_res_valid = tag valid && keep. Suppressed results leave o_res/o_res_x/o_res_y holding their last value.
- DRAIN: wait until the tag pipe is empty. o_frame_done pulses the cycle after the last o_res_valid (t_last+4), then -> IDLE.
- i_start while busy: ignored.
- i_abort, any state, highest priority:
  - next cycle state = IDLE; tag pipe flushed; in-flight results never appear.
  - no o_frame_done; o_overrun unchanged.
  - Core line buffers are not cleared; the first two rows of the next frame refill them.
- i_abort and i_start in the same cycle: abort wins; start ignored.
- Arithmetic: coordinates are unsigned and wrap exactly at the parameter bounds; no saturation needed.

Optional Feature:
- Macro CONV_CTRL_BORDER_ZERO_EN.
- Defined: every accepted pixel yields o_res_valid at t+3. Border tags (keep=0) force o_res=0. Output count = IMG_WIDTH*IMG_HEIGHT.
- Undefined: only full windows are emitted. Output count = (IMG_WIDTH-2)*(IMG_HEIGHT-2).

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=4, i_start, then 32 back-to-back pixels of value 5:
  - 12 o_res_valid, first at (x=2,y=2), last at (7,3), all o_res=0.
  - o_frame_done once, 4 cycles after the last pixel; o_busy then low.
- Same frame, pixel = x*10 with gaps (valid every other cycle):
  - each result = 80 (|1*(x-(x-2))*10*4|).
  - each result exactly 3 cycles after its pixel; coordinates match.
- Pixels before i_start:
  - o_conv_valid stays 0; o_overrun=1.
  - next i_start clears o_overrun.
- i_abort after pixel 20 while results are in flight:
  - no o_res_valid from cycle+1; no o_frame_done; state IDLE.
  - a fresh i_start + 32 pixels still yields 12 results.
- i_abort and i_start in the same cycle from RUN: ends in IDLE; o_busy=0.
- With CONV_CTRL_BORDER_ZERO_EN, 8x4 ramp frame: 32 results; those with x<2 or y<2 have o_res=0.
